wb_sel_ctrl: RTL and testbench
==============================

// Module: wb_sel_ctrl
// PURPOSE
//  Write-back sequencer for the register-file write-data mux (3-bit selector).
//  Accepts one write-back request (source code plus destination register) and waits until that source is valid.
//  Then it drives the mux selector, pulses reg_write for exactly one cycle and reports completion.
//  Sits between the main control FSM and the register-file write port.
// PARAMETERS
//  MAX_WAIT  40  cycles in WAIT before the request is aborted with wb_timeout (must be >= 2)
//  CNT_W     6   width of wait counter; 2**CNT_W must be > MAX_WAIT
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  reset_n     in   1  asynchronous, active-low reset
//  req_valid   in   1  write-back request present
//  req_ready   out  1  1 only in IDLE; request accepted when req_valid & req_ready
//  req_src     in   3  source code: 000 load, 001 LO, 010 ALUOUT, 011 shifter, 100 HI, 101 const 227, 110 const 243, 111 aux
//  req_dest    in   5  destination register number
//  mem_valid   in   1  load data valid (may be a 1-cycle pulse)
//  shift_done  in   1  shifter result valid (may be a 1-cycle pulse)
//  muldiv_busy in   1  mult/div unit busy; HI/LO valid only when 0
//  sel         out  3  mux selector, registered
//  reg_write   out  1  register-file write enable, registered
//  reg_dest    out  5  register-file write address, registered
//  wb_done     out  1  1-cycle pulse: write-back completed
//  wb_timeout  out  1  1-cycle pulse: request aborted, no write performed
// BEHAVIOUR
//  States: IDLE, WAIT, WRITE. Reset (async, reset_n=0) forces IDLE and clears the counter and sticky flags.
//  Reset values: sel=000, reg_write=0, reg_dest=0, wb_done=0, wb_timeout=0, req_ready=1.
//  IDLE: req_ready=1. On accept (cycle T):
//   - capture src into sel and dest into reg_dest; go to WAIT; clear counter.
//   - sticky flags start sampling in cycle T (mem_valid / shift_done seen in T are kept).
//  sel holds its last value outside WAIT/WRITE; the mux output stays stable between requests.
//  WAIT: ready condition per captured src:
//   - 000: sticky_mem | mem_valid
//   - 011: sticky_shift | shift_done
//   - 001, 100: !muldiv_busy
//   - 010, 101, 110, 111: always ready
//  WAIT transitions:
//   - ready -> WRITE.
//   - not ready and counter == MAX_WAIT-1 -> IDLE with wb_timeout=1 for one cycle; reg_write stays 0.
//   - otherwise counter += 1.
//  WRITE: lasts exactly 1 cycle; reg_write=1 unless reg_dest==0 ($zero: write suppressed); wb_done=1; sel and reg_dest held; next IDLE.
//  Latency: accept at T, WAIT at T+1, earliest WRITE (reg_write high) at T+2, next accept possible at T+3.
//  Ready and timeout in the same WAIT cycle: ready wins.
//  req_valid while not in IDLE: ignored (not accepted); the requester holds it.
//  wb_done and wb_timeout are never high together. reg_write is never high outside WRITE.
//  Sticky flags clear on entry to IDLE. Data pulses arriving in IDLE with no accept are discarded.
//  Reset mid-operation: any in-flight request is dropped; no reg_write, wb_done or wb_timeout is generated for it.
// TESTING
//  1. ALUOUT: src=010, dest=8 accepted at T -> sel=010 from T+1; reg_write=1, wb_done=1 at T+2 only; req_ready=1 at T+3.
//  2. Load: src=000, dest=9; mem_valid pulses in cycle T (the accept cycle) -> sticky flag holds it; write at T+2.
//     Repeat with the pulse at T+5 -> write at T+6.
//  3. HI: src=100 with muldiv_busy=1 for 32 cycles after accept -> WRITE on the cycle after busy drops.
//     LO with busy held > MAX_WAIT -> wb_timeout pulse at T+MAX_WAIT, no reg_write, back to IDLE.
//  4. Dest 0: src=101, dest=0 -> wb_done at T+2 with reg_write=0. Same for src=110, dest=31 -> reg_write=1, sel=110.
//  5. Drop reset_n mid-WAIT (src=011, shift_done never seen) -> outputs at reset values immediately.
//     After release: req_ready=1 and no done/timeout for the dropped request.
//  6. Back-to-back requests with req_valid held high -> second request accepted only at T+3; first write's reg_dest is unaffected.

Source files
------------

// File: rtl/wb_sel_ctrl.sv
// rtl/wb_sel_ctrl.sv - write-back sequencer for the register-file write-data mux
// Captures one request, waits for its source to become valid, then pulses a single write.
module wb_sel_ctrl #(
  parameter int MAX_WAIT = 40,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_src,
  input  logic [4:0] req_dest,
  input  logic       mem_valid,
  input  logic       shift_done,
  input  logic       muldiv_busy,
  output logic [2:0] sel,
  output logic       reg_write,
  output logic [4:0] reg_dest,
  output logic       wb_done,
  output logic       wb_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             sticky_mem, sticky_shift;
  logic             src_ready, accept;

  // sel already holds the captured source while in WAIT
  always_comb begin
    src_ready = 1'b1;
    case (sel)
      3'b000:         src_ready = sticky_mem | mem_valid;
      3'b011:         src_ready = sticky_shift | shift_done;
      3'b001, 3'b100: src_ready = !muldiv_busy;
      default:        src_ready = 1'b1;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign accept     = req_valid && (state == S_IDLE);
  assign wb_timeout = (state == S_WAIT) && !src_ready && (cnt == LAST_CNT);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid) state_nx = S_WAIT;
      S_WAIT: begin
        if (src_ready)              state_nx = S_WRITE;
        else if (cnt == LAST_CNT)   state_nx = S_IDLE;
      end
      S_WRITE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sticky_mem   <= 1'b0;
      sticky_shift <= 1'b0;
      sel          <= 3'b000;
      reg_dest     <= 5'd0;
      reg_write    <= 1'b0;
      wb_done      <= 1'b0;
    end else begin
      state     <= state_nx;
      reg_write <= 1'b0;
      wb_done   <= 1'b0;
      if (accept) begin
        sel          <= req_src;
        reg_dest     <= req_dest;
        cnt          <= '0;
        sticky_mem   <= mem_valid;
        sticky_shift <= shift_done;
      end else if (state == S_WAIT) begin
        sticky_mem   <= sticky_mem | mem_valid;
        sticky_shift <= sticky_shift | shift_done;
        if (src_ready) begin
          reg_write <= (reg_dest != 5'd0);
          wb_done   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // pulses seen outside a request are dropped
        sticky_mem   <= 1'b0;
        sticky_shift <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_sel_ctrl.sv
// tb/tb_wb_sel_ctrl.sv - randomized scoreboard bench for wb_sel_ctrl
// Driver predicts each request's outcome from its input plan; a monitor pops and compares.
module tb_wb_sel_ctrl;

  localparam int MAXW = 40;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready;
  logic [2:0] req_src;
  logic [4:0] req_dest;
  logic       mem_valid, shift_done, muldiv_busy;
  logic [2:0] sel;
  logic       reg_write, wb_done, wb_timeout;
  logic [4:0] reg_dest;

  wb_sel_ctrl #(.MAX_WAIT(MAXW), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dest(req_dest), .mem_valid(mem_valid),
    .shift_done(shift_done), .muldiv_busy(muldiv_busy), .sel(sel),
    .reg_write(reg_write), .reg_dest(reg_dest), .wb_done(wb_done),
    .wb_timeout(wb_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 1 = done, 2 = timeout
    int cyc;
    int sel;
    int dest;
    int wr;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  next_acc = -1;

  function automatic void chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && (wb_done || wb_timeout || reg_write)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {wb_timeout, wb_done, reg_write}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, wb_timeout, wb_done}, e.kind);
          chk("event_cycle", cyc, e.cyc);
          chk("event_sel", int'(sel), e.sel);
          chk("event_dest", int'(reg_dest), e.dest);
          chk("event_reg_write", int'(reg_write), e.wr);
        end
      end
    end
  end

  // pk: cycle offset of the data pulse (k=0 is the accept cycle); bl: busy through offset bl
  task automatic issue(input logic [2:0] s, input logic [4:0] d, input int pk,
                       input int bl, input bit noise, input int gap);
    bit  m[MAXW+1];
    bit  sh[MAXW+1];
    bit  b[MAXW+1];
    int  outk, lastk, t;
    bit  sm, ss, rdy, got;
    ev_t e;
    for (int k = 0; k <= MAXW; k++) begin
      m[k]  = (k == pk) || (noise && $urandom_range(0, 19) == 0);
      sh[k] = (k == pk) || (noise && $urandom_range(0, 19) == 0);
      b[k]  = (k <= bl);
    end
    outk = -1; sm = 0; ss = 0;
    for (int k = 0; k <= MAXW && outk < 0; k++) begin
      if (k >= 1) begin
        case (s)
          3'd0:       rdy = sm || m[k];
          3'd3:       rdy = ss || sh[k];
          3'd1, 3'd4: rdy = !b[k];
          default:    rdy = 1'b1;
        endcase
        if (rdy) outk = k;
      end
      sm = sm | m[k];
      ss = ss | sh[k];
    end

    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      req_valid   = 1'b0;
      mem_valid   = ($urandom_range(0, 2) == 0);
      shift_done  = ($urandom_range(0, 2) == 0);
      muldiv_busy = 1'($urandom);
    end
    got = 0;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      req_valid = 1'b1; req_src = s; req_dest = d;
      mem_valid = m[0]; shift_done = sh[0]; muldiv_busy = b[0];
      if (req_ready) got = 1;
    end
    if (!got) begin
      chk("accept_wait_expired", 0, 1);
      return;
    end
    t = cyc;
    if (next_acc >= 0) chk("accept_cycle", t, next_acc + gap);

    e.kind = (outk < 0) ? 2 : 1;
    e.cyc  = (outk < 0) ? t + MAXW : t + outk + 1;
    e.sel  = int'(s);
    e.dest = int'(d);
    e.wr   = (outk >= 0 && d != 5'd0) ? 1 : 0;
    exp_q.push_back(e);

    lastk = (outk < 0) ? MAXW : outk + 1;
    for (int k = 1; k <= lastk; k++) begin
      @(negedge clk);
      // a different request held on the port must be ignored until IDLE
      req_valid = 1'b1;
      req_src   = 3'($urandom);
      req_dest  = 5'($urandom);
      if (k <= MAXW) begin
        mem_valid = m[k]; shift_done = sh[k]; muldiv_busy = b[k];
      end else begin
        mem_valid = 1'($urandom); shift_done = 1'($urandom); muldiv_busy = 1'($urandom);
      end
    end
    next_acc = t + lastk + 1;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_src = 3'd0; req_dest = 5'd0;
    mem_valid = 1'b0; shift_done = 1'b0; muldiv_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_reg_write", int'(reg_write), 0);
    chk("rst_reg_dest", int'(reg_dest), 0);
    chk("rst_wb_done", int'(wb_done), 0);
    chk("rst_wb_timeout", int'(wb_timeout), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;

    issue(3'b010, 5'd8, -1, -1, 0, 0);
    issue(3'b000, 5'd9, 0, -1, 0, 0);
    issue(3'b000, 5'd9, 5, -1, 0, 0);
    issue(3'b100, 5'd5, -1, 32, 0, 0);
    issue(3'b001, 5'd6, -1, 1000, 0, 0);
    issue(3'b101, 5'd0, -1, -1, 0, 0);
    issue(3'b110, 5'd31, -1, -1, 0, 0);
    issue(3'b011, 5'd3, MAXW, -1, 0, 0);
    issue(3'b011, 5'd3, MAXW + 1, -1, 0, 1);

    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom_range(0, MAXW + 8),
            $urandom_range(0, MAXW + 8) - 1,
            1'($urandom),
            ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
    end

    @(negedge clk);
    req_valid = 1'b0;
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // abort a shifter request mid-WAIT with reset
    @(negedge clk);
    req_valid = 1'b1; req_src = 3'b011; req_dest = 5'd12;
    mem_valid = 1'b0; shift_done = 1'b0; muldiv_busy = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_in_wait", int'(req_ready), 0);
    chk("pre_reset_sel", int'(sel), 3);
    reset_n = 1'b0;
    #1;
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_reg_write", int'(reg_write), 0);
    chk("midrst_reg_dest", int'(reg_dest), 0);
    chk("midrst_wb_done", int'(wb_done), 0);
    chk("midrst_wb_timeout", int'(wb_timeout), 0);
    chk("midrst_req_ready", int'(req_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_req_ready", int'(req_ready), 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      shift_done = ($urandom_range(0, 3) == 0);
      mem_valid  = ($urandom_range(0, 3) == 0);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
